// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the training scheduler and its phase controller bench.
package nn_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACT,
    S_WAIT_IDLE,
    S_ADVANCE,
    S_FINISH,
    S_ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_NOACT   = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL = 2'd3;

  // Phase enables packed as {FPH, FPO, BPH, BPO}.
  localparam logic [3:0] PH_NONE = 4'b0000;
  localparam logic [3:0] PH_FPH  = 4'b1000;
  localparam logic [3:0] PH_FPO  = 4'b0100;
  localparam logic [3:0] PH_BPH  = 4'b0010;
  localparam logic [3:0] PH_BPO  = 4'b0001;

  // Watchdog compare selection: waiting for first activity, or bounding a pass.
  localparam logic WD_ACT  = 1'b0;
  localparam logic WD_PASS = 1'b1;

endpackage

// File: rtl/nn_phase_watchdog.sv
// Saturating cycle timer with the activity-wait and pass-length limit compares.
module nn_phase_watchdog
  import nn_ctrl_pkg::*;
#(
  parameter int ACT_WAIT = 4,
  parameter int PASS_MAX = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic phase_any,
  input  logic mode,
  output logic act_timeout,
  output logic pass_overrun
);

  localparam int LIM   = (ACT_WAIT > PASS_MAX) ? ACT_WAIT : PASS_MAX;
  localparam int TMR_W = $clog2(LIM + 1);
  localparam logic [TMR_W-1:0] TMR_SAT   = '1;
  localparam logic [TMR_W-1:0] ACT_LAST  = TMR_W'(ACT_WAIT - 1);
  localparam logic [TMR_W-1:0] PASS_LAST = TMR_W'(PASS_MAX - 1);

  logic [TMR_W-1:0] timer_q, timer_d;

  // Next timer value: clear wins, otherwise count while enabled and stick at all-ones.
  always_comb begin
    // NOTE: default assignment first so every path assigns timer_d and no latch is inferred.
    timer_d = timer_q;
    if (clear) begin
      timer_d = '0;
    end else if (enable && (timer_q != TMR_SAT)) begin
      timer_d = timer_q + TMR_W'(1);
    end
  end

  // Timer register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  // The timer holds the number of cycles already spent in the wait, so the limit
  // is hit on the cycle whose index is LIMIT-1.
  assign act_timeout  = enable && (mode == WD_ACT)  && !phase_any && (timer_q >= ACT_LAST);
  assign pass_overrun = enable && (mode == WD_PASS) &&  phase_any && (timer_q >= PASS_LAST);

endmodule

// File: rtl/nn_train_scheduler.sv
// Issues TR/VL requests to the phase controller and steps sample/epoch counters.
module nn_train_scheduler
  import nn_ctrl_pkg::*;
#(
  parameter int N_TRAIN  = 16,
  parameter int N_VAL    = 4,
  parameter int N_EPOCH  = 8,
  parameter int IDX_W    = 8,
  parameter int EP_W     = 8,
  parameter int ACT_WAIT = 4,
  parameter int PASS_MAX = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             FPH,
  input  logic             FPO,
  input  logic             BPH,
  input  logic             BPO,
  output logic             TR,
  output logic             VL,
  output logic [IDX_W-1:0] sample_idx,
  output logic [EP_W-1:0]  epoch,
  output logic             is_val,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam longint IDX_CAP = longint'(1) << IDX_W;
  localparam longint EP_CAP  = longint'(1) << EP_W;

  if (longint'(N_TRAIN) > IDX_CAP) begin : g_chk_n_train
    $error("N_TRAIN does not fit in IDX_W bits");
  end
  if (longint'(N_VAL) > IDX_CAP) begin : g_chk_n_val
    $error("N_VAL does not fit in IDX_W bits");
  end
  if (longint'(N_EPOCH) > EP_CAP) begin : g_chk_n_epoch
    $error("N_EPOCH does not fit in EP_W bits");
  end

  localparam logic [IDX_W-1:0] LAST_TR = IDX_W'(N_TRAIN - 1);
  localparam logic [IDX_W-1:0] LAST_VL = IDX_W'((N_VAL > 0) ? (N_VAL - 1) : 0);
  localparam logic [EP_W-1:0]  LAST_EP = EP_W'(N_EPOCH - 1);
  localparam logic             HAS_VAL = (N_VAL > 0);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [EP_W-1:0]  epoch_q, epoch_d;
  logic             is_val_q, is_val_d;
  logic             tr_q, tr_d, vl_q, vl_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic phase_any, wd_clear, wd_enable, wd_mode, act_timeout, pass_overrun;

  assign phase_any = FPH | FPO | BPH | BPO;
  assign wd_clear  = (state_q == S_ISSUE) || ((state_q == S_WAIT_ACT) && phase_any);
  assign wd_enable = (state_q == S_WAIT_ACT) || (state_q == S_WAIT_IDLE);
  assign wd_mode   = (state_q == S_WAIT_IDLE) ? WD_PASS : WD_ACT;

  nn_phase_watchdog #(
    .ACT_WAIT (ACT_WAIT),
    .PASS_MAX (PASS_MAX)
  ) u_watchdog (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (wd_clear),
    .enable       (wd_enable),
    .phase_any    (phase_any),
    .mode         (wd_mode),
    .act_timeout  (act_timeout),
    .pass_overrun (pass_overrun)
  );

  // Next-state, counter stepping and registered-output decode.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    epoch_d    = epoch_q;
    is_val_d   = is_val_q;
    err_code_d = err_code_q;

    case (state_q)
      S_IDLE: begin
        if (start && !err_q) begin
          state_d  = S_ISSUE;
          idx_d    = '0;
          epoch_d  = '0;
          is_val_d = 1'b0;
        end
      end
      S_ISSUE: state_d = S_WAIT_ACT;
      S_WAIT_ACT: begin
        if (phase_any) begin
          state_d = S_WAIT_IDLE;
        end else if (act_timeout) begin
          state_d    = S_ERROR;
          err_code_d = ERR_NOACT;
        end
      end
      S_WAIT_IDLE: begin
        // Backward phases have no meaning on a validation pass.
        if (is_val_q && (BPH || BPO)) begin
          state_d    = S_ERROR;
          err_code_d = ERR_ILLEGAL;
        end else if (!phase_any) begin
          state_d = S_ADVANCE;
        end else if (pass_overrun) begin
          state_d    = S_ERROR;
          err_code_d = ERR_OVERRUN;
        end
      end
      S_ADVANCE: begin
        state_d = S_ISSUE;
        if (!is_val_q && (idx_q < LAST_TR)) begin
          idx_d = idx_q + IDX_W'(1);
        end else if (!is_val_q && HAS_VAL) begin
          is_val_d = 1'b1;
          idx_d    = '0;
        end else if (is_val_q && (idx_q < LAST_VL)) begin
          idx_d = idx_q + IDX_W'(1);
        end else if (epoch_q < LAST_EP) begin
          epoch_d  = epoch_q + EP_W'(1);
          is_val_d = 1'b0;
          idx_d    = '0;
        end else begin
          // Final epoch done: counters keep their last values for the host to read.
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with the state register.
    tr_d   = (state_d == S_ISSUE) && !is_val_d;
    vl_d   = (state_d == S_ISSUE) &&  is_val_d;
    busy_d = (state_d != S_IDLE) && (state_d != S_ERROR);
    done_d = (state_d == S_FINISH);
    err_d  = (state_d == S_ERROR);
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      epoch_q    <= '0;
      is_val_q   <= 1'b0;
      tr_q       <= 1'b0;
      vl_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      epoch_q    <= epoch_d;
      is_val_q   <= is_val_d;
      tr_q       <= tr_d;
      vl_q       <= vl_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign TR         = tr_q;
  assign VL         = vl_q;
  assign sample_idx = idx_q;
  assign epoch      = epoch_q;
  assign is_val     = is_val_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_nn_train_scheduler.sv
// Directed bench: A has N_TRAIN=2/N_VAL=1/N_EPOCH=2, B has N_VAL=0.
module tb_nn_train_scheduler;
  import nn_ctrl_pkg::*;

  localparam int IDX_W = 8;
  localparam int EP_W  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n   = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [3:0] ph      = PH_NONE;   // {FPH, FPO, BPH, BPO}, shared by both instances

  logic             tr_a, vl_a, is_val_a, busy_a, done_a, err_a;
  logic [IDX_W-1:0] idx_a;
  logic [EP_W-1:0]  ep_a;
  logic [1:0]       code_a;
  logic             tr_b, vl_b, is_val_b, busy_b, done_b, err_b;
  logic [IDX_W-1:0] idx_b;
  logic [EP_W-1:0]  ep_b;
  logic [1:0]       code_b;

  nn_train_scheduler #(
    .N_TRAIN(2), .N_VAL(1), .N_EPOCH(2), .IDX_W(IDX_W), .EP_W(EP_W),
    .ACT_WAIT(4), .PASS_MAX(64)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .FPH(ph[3]), .FPO(ph[2]), .BPH(ph[1]), .BPO(ph[0]),
    .TR(tr_a), .VL(vl_a), .sample_idx(idx_a), .epoch(ep_a), .is_val(is_val_a),
    .busy(busy_a), .done(done_a), .err(err_a), .err_code(code_a)
  );

  nn_train_scheduler #(
    .N_TRAIN(2), .N_VAL(0), .N_EPOCH(2), .IDX_W(IDX_W), .EP_W(EP_W),
    .ACT_WAIT(4), .PASS_MAX(64)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .FPH(ph[3]), .FPO(ph[2]), .BPH(ph[1]), .BPO(ph[0]),
    .TR(tr_b), .VL(vl_b), .sample_idx(idx_b), .epoch(ep_b), .is_val(is_val_b),
    .busy(busy_b), .done(done_b), .err(err_b), .err_code(code_b)
  );

  // Observation mux: sel=0 watches A, sel=1 watches B.
  bit sel = 1'b0;
  logic             o_tr, o_vl, o_is_val, o_busy, o_done, o_err;
  logic [IDX_W-1:0] o_idx;
  logic [EP_W-1:0]  o_ep;
  logic [1:0]       o_code;
  assign o_tr     = sel ? tr_b     : tr_a;
  assign o_vl     = sel ? vl_b     : vl_a;
  assign o_is_val = sel ? is_val_b : is_val_a;
  assign o_busy   = sel ? busy_b   : busy_a;
  assign o_done   = sel ? done_b   : done_a;
  assign o_err    = sel ? err_b    : err_a;
  assign o_idx    = sel ? idx_b    : idx_a;
  assign o_ep     = sel ? ep_b     : ep_a;
  assign o_code   = sel ? code_b   : code_a;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {8'd0, o_tr, o_vl, o_busy, o_done, o_err, o_code, o_is_val, o_idx, o_ep};
  endfunction

  task automatic do_reset();
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    ph      = PH_NONE;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits a bounded number of cycles for TR or VL; drops start once seen.
  task automatic wait_req(input string tag, output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (o_tr || o_vl) got = 1'b1;
    end
    start_a = 1'b0;
    start_b = 1'b0;
    check({tag, "_req_seen"}, 32'(got), 32'd1);
  endtask

  // Acts as the phase controller for one pass and checks the request itself.
  task automatic serve(input string tag, input bit exp_val,
                       input logic [7:0] exp_idx, input logic [7:0] exp_ep);
    bit got;
    wait_req(tag, got);
    if (got) begin
      check({tag, "_kind"},   32'({o_tr, o_vl}), exp_val ? 32'd1 : 32'd2);
      check({tag, "_idx"},    32'(o_idx), 32'(exp_idx));
      check({tag, "_epoch"},  32'(o_ep), 32'(exp_ep));
      check({tag, "_is_val"}, 32'(o_is_val), 32'(exp_val));
      ph = PH_FPH;
      @(negedge clk);
      check({tag, "_pulse_width"}, 32'({o_tr, o_vl}), 32'd0);
      ph = PH_FPO;
      @(negedge clk);
      if (!exp_val) begin
        ph = PH_BPO;
        @(negedge clk);
        ph = PH_BPH;
        @(negedge clk);
      end
      ph = PH_NONE;
    end
  endtask

  // Watches a window after the last pass: exactly one done, no further requests.
  task automatic expect_done(input string tag);
    int done_cnt = 0;
    int req_cnt  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_done) done_cnt++;
      if (o_tr || o_vl) req_cnt++;
    end
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_extra_reqs"},  32'(req_cnt),  32'd0);
    check({tag, "_busy_after"},  32'(o_busy),   32'd0);
    check({tag, "_err_after"},   32'(o_err),    32'd0);
  endtask

  initial begin
    bit got;
    int req_cnt;

    // Reset state.
    sel = 1'b0;
    do_reset();
    @(negedge clk);
    check("reset_outputs_a", out_vec(), 32'd0);

    // Full run on A: TR,TR,VL,TR,TR,VL.
    start_a = 1'b1;
    serve("a_e0_t0", 1'b0, 8'd0, 8'd0);
    serve("a_e0_t1", 1'b0, 8'd1, 8'd0);
    serve("a_e0_v0", 1'b1, 8'd0, 8'd0);
    serve("a_e1_t0", 1'b0, 8'd0, 8'd1);
    serve("a_e1_t1", 1'b0, 8'd1, 8'd1);
    serve("a_e1_v0", 1'b1, 8'd0, 8'd1);
    expect_done("a_run");
    check("a_final_epoch",  32'(o_ep),     32'd1);
    check("a_final_idx",    32'(o_idx),    32'd0);
    check("a_final_is_val", 32'(o_is_val), 32'd1);

    // No activity after a request: error 4 cycles after TR drops.
    do_reset();
    start_a = 1'b1;
    wait_req("noact", got);
    repeat (4) @(negedge clk);
    check("noact_err_early", 32'(o_err), 32'd0);
    @(negedge clk);
    check("noact_err",      32'(o_err),  32'd1);
    check("noact_code",     32'(o_code), 32'(ERR_NOACT));
    check("noact_busy",     32'(o_busy), 32'd0);
    start_a = 1'b1;
    req_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_tr || o_vl) req_cnt++;
    end
    start_a = 1'b0;
    check("noact_no_reqs",   32'(req_cnt), 32'd0);
    check("noact_err_held",  32'(o_err),   32'd1);
    check("noact_code_held", 32'(o_code),  32'(ERR_NOACT));
    check("noact_start_ign", 32'(o_busy),  32'd0);

    // FPH stuck high: overrun after 64 cycles in the pass.
    do_reset();
    start_a = 1'b1;
    wait_req("overrun", got);
    ph = PH_FPH;
    repeat (65) @(negedge clk);
    check("overrun_err_early", 32'(o_err), 32'd0);
    @(negedge clk);
    check("overrun_err",  32'(o_err),  32'd1);
    check("overrun_code", 32'(o_code), 32'(ERR_OVERRUN));

    // BPO during a validation pass.
    do_reset();
    start_a = 1'b1;
    serve("ill_t0", 1'b0, 8'd0, 8'd0);
    serve("ill_t1", 1'b0, 8'd1, 8'd0);
    wait_req("ill_v0", got);
    check("ill_v0_kind", 32'({o_tr, o_vl}), 32'd1);
    ph = PH_FPH;
    @(negedge clk);
    ph = PH_FPO;
    @(negedge clk);
    ph = PH_BPO;
    check("ill_err_early", 32'(o_err), 32'd0);
    @(negedge clk);
    check("ill_err",  32'(o_err),  32'd1);
    check("ill_code", 32'(o_code), 32'(ERR_ILLEGAL));

    // Reset during WAIT_IDLE of epoch 1, then restart from zero.
    do_reset();
    start_a = 1'b1;
    serve("mid_e0_t0", 1'b0, 8'd0, 8'd0);
    serve("mid_e0_t1", 1'b0, 8'd1, 8'd0);
    serve("mid_e0_v0", 1'b1, 8'd0, 8'd0);
    wait_req("mid_e1_t0", got);
    check("mid_e1_epoch", 32'(o_ep), 32'd1);
    ph = PH_FPH;
    @(negedge clk);
    ph = PH_FPO;
    @(negedge clk);
    check("mid_busy_before", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_reset_outputs", out_vec(), 32'd0);
    ph      = PH_NONE;
    rst_n   = 1'b1;
    start_a = 1'b1;
    serve("mid_restart", 1'b0, 8'd0, 8'd0);

    // N_VAL=0 on B: four training passes, no VL, then done.
    sel = 1'b1;
    do_reset();
    @(negedge clk);
    check("reset_outputs_b", out_vec(), 32'd0);
    start_b = 1'b1;
    serve("b_e0_t0", 1'b0, 8'd0, 8'd0);
    serve("b_e0_t1", 1'b0, 8'd1, 8'd0);
    serve("b_e1_t0", 1'b0, 8'd0, 8'd1);
    serve("b_e1_t1", 1'b0, 8'd1, 8'd1);
    expect_done("b_run");
    check("b_final_epoch",  32'(o_ep),     32'd1);
    check("b_final_idx",    32'(o_idx),    32'd1);
    check("b_final_is_val", 32'(o_is_val), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
